// File: rtl/exec_unit.sv
// Multi-cycle execute unit: register file, ALU, IDLE->EXEC->WB sequencer.
// Optional shift-add multiplier (opcode 20) enabled by defining EXEC_UNIT_MUL_EN.
module exec_unit #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        opcode,
  input  logic [RW-1:0]     rd,
  input  logic [RW-1:0]     ra,
  input  logic [RW-1:0]     rb,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [RW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
`ifdef EXEC_UNIT_MUL_EN
    , MUL = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          op_q;
  logic [RW-1:0]       rd_q;
  logic [DATA_W-1:0]   a_q, b_q, res_q;
  logic                wr_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   alu;
  logic                alu_wr;
  logic                imm_op;
`ifdef EXEC_UNIT_MUL_EN
  localparam int CW = $clog2(DATA_W);
  logic [CW-1:0]       cnt_q;
`endif

  assign imm_op      = (opcode >= 5'd7) && (opcode <= 5'd13);
  assign instr_ready = (state_q == IDLE) && !reset;
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (instr_valid) state_d = EXEC;
      EXEC: begin
        state_d = WB;
`ifdef EXEC_UNIT_MUL_EN
        if (op_q == 5'd20) state_d = MUL;
`endif
      end
`ifdef EXEC_UNIT_MUL_EN
      MUL:  if (cnt_q == CW'(DATA_W - 1)) state_d = WB;
`endif
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unlisted opcodes fall to default: result 0 and no write-back (NOP).
  always_comb begin
    alu    = '0;
    alu_wr = 1'b1;
    case (op_q)
      5'd0,  5'd7:  alu = a_q + b_q;
      5'd1,  5'd8:  alu = a_q - b_q;
      5'd2,  5'd9:  alu = a_q | b_q;
      5'd3,  5'd10: alu = a_q & b_q;
      5'd4,  5'd11: alu = a_q ^ b_q;
      5'd5,  5'd12: alu = a_q << b_q[SHW-1:0];
      5'd6,  5'd13: alu = a_q >> b_q[SHW-1:0];
      5'd15:        alu = {{(DATA_W-1){1'b0}}, (a_q > b_q)};
      5'd16:        alu = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      5'd17:        alu = {{(DATA_W-1){1'b0}}, (a_q == b_q)};
`ifdef EXEC_UNIT_MUL_EN
      5'd20:        alu = '0;
`endif
      default:      alu_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      wr_q         <= 1'b0;
      regs         <= '{default: '0};
      result       <= '0;
      result_valid <= 1'b0;
      flag_z       <= 1'b0;
      flag_n       <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      cnt_q        <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          op_q <= opcode;
          rd_q <= rd;
          a_q  <= regs[ra];
          b_q  <= imm_op ? DATA_W'(imm) : regs[rb];
        end
        EXEC: begin
          res_q <= alu;
          wr_q  <= alu_wr;
`ifdef EXEC_UNIT_MUL_EN
          cnt_q <= '0;
`endif
        end
`ifdef EXEC_UNIT_MUL_EN
        // res_q starts at zero from EXEC and accumulates one partial product per cycle.
        MUL: begin
          if (b_q[0]) res_q <= res_q + a_q;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
`endif
        WB: begin
          result       <= res_q;
          result_valid <= 1'b1;
          if (wr_q) begin
            regs[rd_q] <= res_q;
            flag_z     <= (res_q == '0);
            flag_n     <= res_q[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected responses,
// a negedge monitor pops and checks them on every result_valid.
module tb_exec_unit;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [4:0]    opcode = '0;
  logic [2:0]    rd = '0, ra = '0, rb = '0, dbg_addr = '0;
  logic [IW-1:0] imm = '0;
  logic [DW-1:0] result, dbg_data;
  logic          result_valid, flag_z, flag_n;

  typedef struct {
    string         name;
    logic [DW-1:0] res;
    logic          z;
    logic          n;
    int            hs;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mz = 1'b0, mn = 1'b0;
  int   w;

  exec_unit #(.DATA_W(DW), .NREGS(NR), .IMM_W(IW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
    .result(result), .result_valid(result_valid),
    .flag_z(flag_z), .flag_n(flag_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // lat is handshake-to-result_valid in edges; monitor sees it one edge later at negedge.
  task automatic issue(input string nm, input logic [4:0] op, input int rd_i, input int ra_i,
                       input int rb_i, input int imm_i, input logic [DW-1:0] exp_res,
                       input bit wr, input int lat, input bit hold, output int waits);
    exp_t e;
    @(negedge clk);
    opcode = op; rd = 3'(rd_i); ra = 3'(ra_i); rb = 3'(rb_i); imm = IW'(imm_i);
    instr_valid = 1'b1;
    waits = 0;
    while (!instr_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) begin
      chk({nm, "_ready_timeout"}, 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    if (wr) begin
      mz = (exp_res == '0);
      mn = exp_res[DW-1];
    end
    e.name = nm; e.res = exp_res; e.z = mz; e.n = mn; e.hs = cyc; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    if (!hold) #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic dbg_chk(input int idx, input logic [DW-1:0] v);
    dbg_addr = 3'(idx);
    #1 chk($sformatf("reg%0d", idx), 32'(dbg_data), 32'(v));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_result_valid", 32'(result_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_res"}, 32'(result), 32'(e.res));
          chk({e.name, "_z"}, 32'(flag_z), 32'(e.z));
          chk({e.name, "_n"}, 32'(flag_n), 32'(e.n));
          chk({e.name, "_lat"}, cyc - e.hs, e.lat + 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_reset", 32'(instr_ready), 32'd1);
    dbg_chk(3, 16'h0000);

    issue("addi1", 5'd7,  1, 0, 0, 5,   16'h0005, 1'b1, 2, 1'b0, w);
    issue("addi2", 5'd7,  2, 0, 0, 3,   16'h0003, 1'b1, 2, 1'b0, w);
    issue("sub",   5'd1,  3, 2, 1, 0,   16'hFFFE, 1'b1, 2, 1'b0, w);
    issue("nop14", 5'd14, 1, 2, 2, 0,   16'h0000, 1'b0, 2, 1'b0, w);
    issue("eq",    5'd17, 4, 1, 1, 0,   16'h0001, 1'b1, 2, 1'b0, w);
    issue("xor",   5'd4,  5, 1, 1, 0,   16'h0000, 1'b1, 2, 1'b0, w);
    issue("sli",   5'd12, 6, 1, 0, 17,  16'h000A, 1'b1, 2, 1'b0, w);
    issue("or",    5'd2,  7, 1, 3, 0,   16'hFFFF, 1'b1, 2, 1'b0, w);
    issue("gt",    5'd15, 7, 3, 1, 0,   16'h0001, 1'b1, 2, 1'b0, w);
    issue("lt",    5'd16, 7, 3, 1, 0,   16'h0000, 1'b1, 2, 1'b0, w);
    issue("sri",   5'd13, 7, 3, 0, 4,   16'h0FFF, 1'b1, 2, 1'b0, w);
    issue("and",   5'd3,  7, 3, 6, 0,   16'h000A, 1'b1, 2, 1'b0, w);
    issue("sr",    5'd6,  7, 3, 4, 0,   16'h7FFF, 1'b1, 2, 1'b0, w);
    issue("addself", 5'd0, 1, 1, 1, 0,  16'h000A, 1'b1, 2, 1'b0, w);
    issue("subi",  5'd8,  7, 6, 0, 10,  16'h0000, 1'b1, 2, 1'b0, w);
    issue("nop18", 5'd18, 3, 1, 1, 0,   16'h0000, 1'b0, 2, 1'b0, w);
    issue("nop19", 5'd19, 3, 1, 1, 0,   16'h0000, 1'b0, 2, 1'b0, w);
    issue("nop31", 5'd31, 3, 1, 1, 0,   16'h0000, 1'b0, 2, 1'b0, w);
    issue("addi150", 5'd7, 7, 0, 0, 150, 16'h0096, 1'b1, 2, 1'b0, w);
    issue("add300", 5'd0, 7, 7, 7, 0,   16'h012C, 1'b1, 2, 1'b0, w);
`ifdef EXEC_UNIT_MUL_EN
    issue("mul",   5'd20, 2, 7, 7, 0,   16'h5F90, 1'b1, DW + 2, 1'b0, w);
`else
    issue("mul_nop", 5'd20, 2, 7, 7, 0, 16'h0000, 1'b0, 2, 1'b0, w);
`endif
    issue("wrap",  5'd7,  5, 3, 0, 2,   16'h0000, 1'b1, 2, 1'b0, w);
    drain();

    dbg_chk(0, 16'h0000);
    dbg_chk(1, 16'h000A);
`ifdef EXEC_UNIT_MUL_EN
    dbg_chk(2, 16'h5F90);
`else
    dbg_chk(2, 16'h0003);
`endif
    dbg_chk(3, 16'hFFFE);
    dbg_chk(4, 16'h0001);
    dbg_chk(5, 16'h0000);
    dbg_chk(6, 16'h000A);
    dbg_chk(7, 16'h012C);

    // instr_valid held high across three back-to-back instructions.
    issue("b2b0", 5'd7, 4, 0, 0, 8'h11, 16'h0011, 1'b1, 2, 1'b1, w);
    issue("b2b1", 5'd7, 5, 4, 0, 1,     16'h0012, 1'b1, 2, 1'b1, w);
    chk("b2b1_not_ready_cycles", w, 2);
    issue("b2b2", 5'd7, 6, 5, 0, 1,     16'h0013, 1'b1, 2, 1'b0, w);
    chk("b2b2_not_ready_cycles", w, 2);
    drain();
    dbg_chk(4, 16'h0011);
    dbg_chk(5, 16'h0012);
    dbg_chk(6, 16'h0013);

    // Reset during EXEC of ADDI r1 = 9 must abort it.
    @(negedge clk);
    opcode = 5'd7; rd = 3'd1; ra = 3'd0; rb = 3'd0; imm = 8'd9;
    instr_valid = 1'b1;
    #1 chk("abort_ready_before", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("abort_ready_in_reset", 32'(instr_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mz = 1'b0; mn = 1'b0;
    #1 chk("abort_ready_after", 32'(instr_ready), 32'd1);
    repeat (4) @(negedge clk);
    dbg_chk(1, 16'h0000);
    dbg_chk(4, 16'h0000);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", {30'd0, flag_z, flag_n}, 32'd0);

    issue("post_rst", 5'd7, 2, 0, 0, 7, 16'h0007, 1'b1, 2, 1'b0, w);
    drain();
    dbg_chk(2, 16'h0007);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
